// File: rtl/csa_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csa_ctrl_pkg
// Purpose  : Shared constants, state encoding and helpers for the
//            nibble-serial carry-select adder sequencer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package csa_ctrl_pkg;

  // Width of the datapath slice processed per pass.
  localparam int SLICE_W = 4;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage : csa_ctrl_pkg
`default_nettype wire

// File: rtl/csa_seq_adder_ctrl_csa.sv
`default_nettype none
// ============================================================================
// Module   : CSA
// Purpose  : 4-bit carry select adder slice. The low two bits ripple; the
//            high two bits are computed for both carry-in values and the
//            correct one is chosen by the low-half carry.
// Ports    : A, B    - 4-bit addends
//            cin     - carry into bit 0
//            sum     - 4-bit sum
//            cout    - carry out of bit 3
// Revision : 1.0 - initial release
// ============================================================================
module CSA (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [2:0] w_lo;
  logic [2:0] w_hi0;
  logic [2:0] w_hi1;

  assign w_lo  = {1'b0, A[1:0]} + {1'b0, B[1:0]} + {2'b00, cin};
  assign w_hi0 = {1'b0, A[3:2]} + {1'b0, B[3:2]};
  assign w_hi1 = {1'b0, A[3:2]} + {1'b0, B[3:2]} + 3'd1;

  always_comb begin
    sum[1:0] = w_lo[1:0];
    if (w_lo[2]) begin
      sum[3:2] = w_hi1[1:0];
      cout     = w_hi1[2];
    end else begin
      sum[3:2] = w_hi0[1:0];
      cout     = w_hi0[2];
    end
  end

endmodule : CSA
`default_nettype wire

// File: rtl/csa_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csa_seq_adder_ctrl
// Purpose  : Adds two WIDTH-bit operands by time-multiplexing one 4-bit
//            carry select adder slice, LSB nibble first, with a registered
//            carry between passes. Valid/ready on operand and result sides.
// Params   : WIDTH - operand/result width, multiple of 4 and >= 8
// Ports    : clk, rst_n          - clock, async active-low reset
//            in_valid/in_ready   - operand handshake (a, b, cin)
//            out_valid/out_ready - result handshake (sum, cout)
//            busy                - high while an operation is in flight
//            ovf                 - signed overflow (CSA_CTRL_OVF_EN only)
// Macro    : CSA_CTRL_OVF_EN - adds the registered two's-complement ovf port
// Revision : 1.0 - initial release
// ============================================================================
module csa_seq_adder_ctrl
  import csa_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CSA_CTRL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = clog2(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;
  logic [WIDTH-1:0]   w_acc_next;

`ifdef CSA_CTRL_OVF_EN
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_ovf;
`endif

  CSA u_slice (
    .A    (r_a[SLICE_W-1:0]),
    .B    (r_b[SLICE_W-1:0]),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // Each pass drops the new nibble into the top; after NSLICE passes the
  // first (LSB) nibble has reached bit 0.
  assign w_acc_next = {w_slice_sum, r_acc[WIDTH-1:SLICE_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef CSA_CTRL_OVF_EN
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_carry    <= cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef CSA_CTRL_OVF_EN
            r_sign_a   <= a[WIDTH-1];
            r_sign_b   <= b[WIDTH-1];
`endif
            r_state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_slice_cout;
          r_a     <= {{SLICE_W{1'b0}}, r_a[WIDTH-1:SLICE_W]};
          r_b     <= {{SLICE_W{1'b0}}, r_b[WIDTH-1:SLICE_W]};
          if (r_cnt == LAST_CNT) begin
            // Visible result changes only here, so it is stable through DONE.
            r_cnt       <= '0;
            r_sum       <= w_acc_next;
            r_cout      <= w_slice_cout;
            r_out_valid <= 1'b1;
`ifdef CSA_CTRL_OVF_EN
            r_ovf       <= (r_sign_a == r_sign_b) &&
                           (w_slice_sum[SLICE_W-1] != r_sign_a);
`endif
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
`ifdef CSA_CTRL_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule : csa_seq_adder_ctrl
`default_nettype wire

// File: tb/tb_csa_seq_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_seq_adder_ctrl
// Purpose  : Self-checking bench for csa_seq_adder_ctrl (WIDTH=16). Expected
//            results are pushed to a queue at operand acceptance and popped
//            when the DUT raises out_valid.
// Macro    : CSA_CTRL_OVF_EN - also checks the ovf port
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_seq_adder_ctrl;

  localparam int WIDTH  = 16;
  localparam int NSLICE = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef CSA_CTRL_OVF_EN
  logic             ovf;
`endif

  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  csa_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef CSA_CTRL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain wide addition plus the signed-overflow rule.
  function automatic exp_t model(input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                                 input logic ecin);
    exp_t             e;
    logic [WIDTH:0]   full;
    full   = {1'b0, ea} + {1'b0, eb} + {{WIDTH{1'b0}}, ecin};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (ea[WIDTH-1] == eb[WIDTH-1]) && (full[WIDTH-1] != ea[WIDTH-1]);
    return e;
  endfunction

  // One complete operation. Called #1 after a rising edge.
  //   hold    - DONE cycles with out_ready low before accepting
  //   early   - raise out_ready before the operation starts
  //   disturb - change operands and pulse in_valid during RUN
  task automatic do_op(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic vcin, input int hold, input bit early, input bit disturb);
    exp_t e;
    int   n;
    check({tag, ":in_ready_idle"}, 32'(in_ready), 32'd1);
    a        = va;
    b        = vb;
    cin      = vcin;
    in_valid = 1'b1;
    out_ready = early;
    sb_q.push_back(model(va, vb, vcin));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
      if (disturb && n == 1) begin
        a        = ~va;
        b        = va ^ vb;
        cin      = ~vcin;
        in_valid = 1'b1;
        check({tag, ":in_ready_run"}, 32'(in_ready), 32'd0);
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check({tag, ":latency"}, 32'(n), 32'(NSLICE));
    e = sb_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check({tag, ":hold_sum"}, 32'(sum), 32'(e.sum));
      check({tag, ":hold_busy"}, 32'(busy), 32'd1);
      check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
    end
    check({tag, ":sum"}, 32'(sum), 32'(e.sum));
    check({tag, ":cout"}, 32'(cout), 32'(e.cout));
`ifdef CSA_CTRL_OVF_EN
    check({tag, ":ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ":post_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":post_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ":post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:in_ready", 32'(in_ready), 32'd1);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:sum", 32'(sum), 32'd0);
    check("rst:cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("zero",   16'h0000, 16'h0000, 1'b0, 0, 1'b0, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    do_op("ones",   16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b1, 1'b0);
    do_op("mixed",  16'h1234, 16'h4321, 1'b1, 0, 1'b0, 1'b1);
    do_op("bp",     16'hA5C3, 16'h1E2F, 1'b0, 3, 1'b0, 1'b0);
    do_op("b2b",    16'h00FF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);

    // Abort mid-RUN with reset.
    a        = 16'hBEEF;
    b        = 16'h1111;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort:busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort:out_valid", 32'(out_valid), 32'd0);
    check("abort:sum", 32'(sum), 32'd0);
    check("abort:in_ready", 32'(in_ready), 32'd1);
    check("abort:busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op("after_rst", 16'h0005, 16'h0003, 1'b0, 0, 1'b0, 1'b0);

`ifdef CSA_CTRL_OVF_EN
    do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 0, 1'b0, 1'b0);
    do_op("ovf_no",  16'h0001, 16'hFFFF, 1'b0, 0, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 4; k++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      do_op("rand", ra, rb, 1'($urandom_range(1)), k % 2, 1'b0, 1'b0);
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_csa_seq_adder_ctrl
`default_nettype wire

// File: doc/csa_seq_adder_ctrl.md
Name: csa_seq_adder_ctrl

Overview:
Sequencer that time-multiplexes one 4-bit carry select adder slice to add WIDTH-bit operands, one nibble per cycle, LSB nibble first.
- Registered carry links the nibbles.
- Valid/ready handshake on both the operand side and the result side.
- Sits between an operand producer and a result consumer wherever a wide add is needed but area forbids a full-width adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
NSLICE, WIDTH/4, derived local constant: number of slice passes per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into bit 0
out_valid  output  1  sum/cout valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, slice counter=0, carry register=0, operand shift registers=0.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, cin into shift registers and carry register, clear counter, go to RUN.
  - RUN: in_ready=0. Each cycle, feed the low nibbles of the A/B shift registers and the carry register to the slice. Shift the slice sum into the top nibble of the sum accumulator (accumulator shifts right by 4). Load the slice cout into the carry register. Shift the A/B registers right by 4. Increment the counter.
  - RUN exit: when counter==NSLICE-1, go to DONE. The counter wraps to 0.
  - DONE: out_valid=1. sum and cout are held stable until out_valid&&out_ready, then go to IDLE.
- Latency: out_valid rises on the NSLICE-th rising edge after the accepting edge (4 edges for WIDTH=16).
- Throughput: one operation per NSLICE+2 cycles minimum. No bypass: in_ready returns high the cycle after the result handshake.
- in_valid or operand changes during RUN/DONE are ignored; operands are latched at acceptance.
- out_ready high before DONE has no effect. If out_ready is already high when DONE is entered, the handshake completes on the first DONE cycle.
- Carry ripples across nibbles unsigned: all-ones + 1 carries through every pass.
- sum and cout update only on the DONE-entry edge.
- Reset asserted mid-RUN or mid-DONE aborts the operation with no result. All outputs return to reset values immediately.

Optional Feature:
Macro CSA_CTRL_OVF_EN.
- Defined: adds output port ovf (1 bit), registered and valid with out_valid.
  - Two's-complement overflow: ovf = (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]).
  - Uses the sign bits captured at acceptance.
  - Reset value 0; held through DONE.
- Not defined: no ovf port, no sign-bit capture registers; behaviour otherwise identical.

Decomposition:
- Shared package csa_ctrl_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - SLICE_W=4.
  - Counter width function clog2(NSLICE).
- Sub-module: one instance of the team's existing 4-bit carry select adder CSA (ports A, B, cin, sum, cout), used as the datapath slice.
- Controller FSM, counter and shift registers stay in csa_seq_adder_ctrl.

Test Plan:
- WIDTH=16, a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0. out_valid rises exactly 4 edges after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses all 4 passes). Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. Change a/b and pulse in_valid during RUN -> result unchanged, in_ready stays 0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> sum/cout stable, busy=1, in_ready=0. Raise out_ready -> in_ready=1 next cycle; back-to-back second op 0x00FF+0x0001 -> 0x0100.
- Assert rst_n=0 two cycles into RUN -> out_valid=0, sum=0, in_ready=1 immediately. After release, 0x0005+0x0003 cin=0 -> 0x0008.
- With CSA_CTRL_OVF_EN:
  - 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
  - 0x8000+0x8000 -> sum=0x0000, ovf=1, cout=1.
  - 0x0001+0xFFFF -> ovf=0.
